// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for signed/unsigned DIV with abort and hold-until-ack handshake
module div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] dvd, dvd_n, rem, rem_n, dsr, dsr_n, a_mag, b_mag;
  logic neg_q, neg_q_n, neg_r, neg_r_n, ready_n;
  logic [2*DATA_W-1:0] result_n;
  logic [DATA_W:0] t;
  // operand magnitudes for signed requests and the trial subtraction of one restoring step
  always_comb begin
    a_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? ~opdata1_i + 1'b1 : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? ~opdata2_i + 1'b1 : opdata2_i;
    t = {rem, dvd[DATA_W-1]} - {1'b0, dsr};
  end
  // next-state and datapath: dvd shifts out dividend bits and shifts in quotient bits
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dvd_n = dvd;
    rem_n = rem;
    dsr_n = dsr;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    result_n = result_o;
    ready_n = ready_o;
    case (state)
      FREE: if (start_i && !annul_i) begin
        dvd_n = a_mag;
        dsr_n = b_mag;
        rem_n = '0;
        cnt_n = '0;
        neg_q_n = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
        neg_r_n = signed_div_i && opdata1_i[DATA_W-1];
        state_n = (opdata2_i == '0) ? BYZERO : ON;
      end
      BYZERO: begin
        cnt_n = cnt + 1'b1;
        if (cnt != '0) begin
          state_n = END;
          result_n = '0;
          ready_n = 1'b1;
        end
      end
      ON: if (annul_i) begin
        state_n = FREE;
        ready_n = 1'b0;
      end else if (cnt == CNT_W'(DATA_W)) begin
        state_n = END;
        result_n = {neg_r ? -rem : rem, neg_q ? -dvd : dvd};
        ready_n = 1'b1;
      end else begin
        rem_n = t[DATA_W] ? {rem[DATA_W-2:0], dvd[DATA_W-1]} : t[DATA_W-1:0];
        dvd_n = {dvd[DATA_W-2:0], ~t[DATA_W]};
        cnt_n = cnt + 1'b1;
      end
      END: if (!start_i) begin
        state_n = FREE;
        ready_n = 1'b0;
        result_n = '0;
      end
      default: state_n = FREE;
    endcase
  end
  // state register; reset is active-low and wins over every request
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FREE;
      cnt <= '0;
      dvd <= '0;
      rem <= '0;
      dsr <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      result_o <= '0;
      ready_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dvd <= dvd_n;
      rem <= rem_n;
      dsr <= dsr_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      result_o <= result_n;
      ready_o <= ready_n;
    end
  end
endmodule
